lfsr_checker: RTL and testbench

//  Receive-side checker for the 8-bit LED pattern LFSR stream.
//  - Takes one 8-bit word per in_valid strobe.
//  - Synchronises a local predictor to the incoming sequence.
//  - Flywheels through errors once locked.
//  - Counts word errors and bit errors.
//  - err_cnt[7:0] is sized to feed the 7-seg digits driver directly.

---
 rtl/lfsr_checker.sv | 177 +++++++++++++++++
 tb/tb_lfsr_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for the 8-bit LED pattern LFSR stream.
// Locks a local predictor onto the incoming words. Once locked, it flywheels
// through errors and keeps saturating word-error and bit-error counts.
module lfsr_checker #(
  parameter int LOCK_CNT = 4,   // consecutive matches needed to lock (1..15)
  parameter int LOSS_CNT = 3,   // consecutive mismatches that drop lock (1..15)
  parameter int ERR_W    = 16   // counter width, saturating (>=4)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] bit_err_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_LOCKED = 2'b10,
    ST_BAD    = 2'b11
  } state_t;

  localparam logic [3:0] LOCK_CNT_L = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_CNT_L = 4'(LOSS_CNT);
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  // Successor of x in the 256-state sequence. The NOR term splices 0x00
  // into the cycle, so the all-zero word is not a lockup state.
  function automatic logic [7:0] lfsr_nxt(input logic [7:0] x);
    return {x[4] ^ x[3] ^ x[2] ^ x[0] ^ ~|x[7:1], x[7:1]};
  endfunction

  state_t           state_reg, state_next;
  logic [7:0]       pred_reg, pred_next;
  logic [3:0]       run_reg, run_next;
  logic             locked_reg, locked_next;
  logic             pulse_reg, pulse_next;
  logic [ERR_W-1:0] err_reg, err_next;
  logic [ERR_W-1:0] bit_reg, bit_next;

  logic [7:0]       diff_bits;
  logic [3:0]       diff_cnt;
  logic [3:0]       run_inc;
  logic             match;
  logic             err_inc;
  logic [ERR_W:0]   bit_sum;

  // Per-bit disagreement between the received word and the prediction.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_diff
      assign diff_bits[gi] = in_data[gi] ^ pred_reg[gi];
    end
  endgenerate

  assign match   = (diff_bits == 8'h00);
  assign run_inc = run_reg + 4'd1;

  // Population count of the differing bits (0..8).
  always_comb begin
    diff_cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      diff_cnt = diff_cnt + {3'b000, diff_bits[i]};
    end
  end

  // Next-state, predictor, run-length and error-event decode.
  always_comb begin
    state_next = state_reg;
    pred_next  = pred_reg;
    run_next   = run_reg;
    pulse_next = 1'b0;
    err_inc    = 1'b0;
    case (state_reg)
      ST_HUNT: begin
        if (in_valid) begin
          pred_next  = lfsr_nxt(in_data);
          run_next   = 4'd0;
          state_next = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (in_valid) begin
          // Always re-seed from the received word while acquiring.
          pred_next = lfsr_nxt(in_data);
          if (match) begin
            if (run_inc == LOCK_CNT_L) begin
              state_next = ST_LOCKED;
              run_next   = 4'd0;
            end else begin
              run_next = run_inc;
            end
          end else begin
            run_next = 4'd0;
          end
        end
      end
      ST_LOCKED: begin
        if (in_valid) begin
          // Flywheel: the prediction advances on its own, ignoring the data.
          pred_next = lfsr_nxt(pred_reg);
          if (match) begin
            run_next = 4'd0;
          end else begin
            pulse_next = 1'b1;
            err_inc    = 1'b1;
            if (run_inc == LOSS_CNT_L) begin
              state_next = ST_HUNT;
              run_next   = 4'd0;
            end else begin
              run_next = run_inc;
            end
          end
        end
      end
      default: begin
        // Unused encoding: recover to HUNT on the next edge.
        state_next = ST_HUNT;
        run_next   = 4'd0;
      end
    endcase
  end

  assign locked_next = (state_next == ST_LOCKED);

  // Saturating counters; clear wins over a same-cycle increment.
  always_comb begin
    err_next = err_reg;
    bit_next = bit_reg;
    bit_sum  = {1'b0, bit_reg} + (ERR_W+1)'(diff_cnt);
    if (clr) begin
      err_next = '0;
      bit_next = '0;
    end else if (err_inc) begin
      if (!(&err_reg)) begin
        err_next = err_reg + ERR_ONE;
      end
      if (bit_sum[ERR_W]) begin
        bit_next = '1;
      end else begin
        bit_next = bit_sum[ERR_W-1:0];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_HUNT;
      pred_reg   <= 8'h00;
      run_reg    <= 4'd0;
      locked_reg <= 1'b0;
      pulse_reg  <= 1'b0;
      err_reg    <= '0;
      bit_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      pred_reg   <= pred_next;
      run_reg    <= run_next;
      locked_reg <= locked_next;
      pulse_reg  <= pulse_next;
      err_reg    <= err_next;
      bit_reg    <= bit_next;
    end
  end

  assign state       = state_reg;
  assign locked      = locked_reg;
  assign err_pulse   = pulse_reg;
  assign err_cnt     = err_reg;
  assign bit_err_cnt = bit_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed test of lfsr_checker (default build and ERR_W=4).
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, clr;
  logic [7:0]  in_data;
  logic        locked, err_pulse;
  logic [15:0] err_cnt, bit_err_cnt;
  logic [1:0]  state;

  logic        v2, c2;
  logic [7:0]  d2;
  logic        locked2, err_pulse2;
  logic [3:0]  err_cnt2, bit_err_cnt2;
  logic [1:0]  state2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] seq_a [5] = '{8'h01, 8'h00, 8'h80, 8'h40, 8'h20};
  logic [7:0] seq_b [5] = '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F};
  logic [7:0] seq_c [5] = '{8'h02, 8'h01, 8'h00, 8'h80, 8'h40};
  logic [1:0] st_exp [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
  logic [7:0] p;

  lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .bit_err_cnt(bit_err_cnt), .state(state)
  );

  lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(d2), .clr(c2),
    .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2),
    .bit_err_cnt(bit_err_cnt2), .state(state2)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[4] ^ x[3] ^ x[2] ^ x[0] ^ ~|x[7:1], x[7:1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] d, input logic c);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; clr = c;
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic send2(input logic [7:0] d, input logic c);
    @(negedge clk);
    v2 = 1'b1; d2 = d; c2 = c;
    @(posedge clk); #1;
    v2 = 1'b0; c2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check({tag, "_pulse"},  {31'd0, err_pulse}, 32'd0);
    check({tag, "_err"},    {16'd0, err_cnt}, 32'd0);
    check({tag, "_bit"},    {16'd0, bit_err_cnt}, 32'd0);
    check({tag, "_state"},  {30'd0, state}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; clr = 1'b0;
    v2 = 1'b0; d2 = 8'h00; c2 = 1'b0;
    idle(2);
    check_zero("rst");
    @(negedge clk); rst_n = 1'b1;

    // 1: lock from 0x01
    for (int i = 0; i < 5; i++) begin
      send(seq_a[i], 1'b0);
      check("lock_state", {30'd0, state}, {30'd0, st_exp[i]});
    end
    check("lock_locked", {31'd0, locked}, 32'd1);
    check("lock_err", {16'd0, err_cnt}, 32'd0);

    // 2: flywheel over a single-bit error, with an idle gap
    send(8'h11, 1'b0);
    check("fly_pulse", {31'd0, err_pulse}, 32'd1);
    check("fly_err", {16'd0, err_cnt}, 32'd1);
    check("fly_bit", {16'd0, bit_err_cnt}, 32'd1);
    idle(1);
    check("idle_pulse", {31'd0, err_pulse}, 32'd0);
    check("idle_err", {16'd0, err_cnt}, 32'd1);
    send(8'h88, 1'b0);
    check("fly_locked", {31'd0, locked}, 32'd1);
    check("fly_pulse2", {31'd0, err_pulse}, 32'd0);
    check("fly_err2", {16'd0, err_cnt}, 32'd1);

    // clr without a word
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    check("clr_err", {16'd0, err_cnt}, 32'd0);
    check("clr_bit", {16'd0, bit_err_cnt}, 32'd0);
    check("clr_locked", {31'd0, locked}, 32'd1);

    // 3: loss of lock (preds C4, E2, 71 inverted)
    send(8'h3B, 1'b0);
    check("loss1_locked", {31'd0, locked}, 32'd1);
    check("loss1_bit", {16'd0, bit_err_cnt}, 32'd8);
    send(8'h1D, 1'b0);
    check("loss2_locked", {31'd0, locked}, 32'd1);
    check("loss2_err", {16'd0, err_cnt}, 32'd2);
    send(8'h8E, 1'b0);
    check("loss3_locked", {31'd0, locked}, 32'd0);
    check("loss3_state", {30'd0, state}, 32'd0);
    check("loss3_err", {16'd0, err_cnt}, 32'd3);
    check("loss3_bit", {16'd0, bit_err_cnt}, 32'd24);
    check("loss3_pulse", {31'd0, err_pulse}, 32'd1);

    // 4a: lock from 0xFF after clearing counters
    send(8'hFF, 1'b1);
    check("ff_state0", {30'd0, state}, 32'd1);
    check("ff_err0", {16'd0, err_cnt}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      send(seq_b[i], 1'b0);
      check("ff_state", {30'd0, state}, {30'd0, st_exp[i]});
    end
    check("ff_locked", {31'd0, locked}, 32'd1);
    check("ff_bit", {16'd0, bit_err_cnt}, 32'd0);

    // 4b: reset, then lock through 0x01 -> 0x00 -> 0x80
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(seq_c[i], 1'b0);
      check("zero_state", {30'd0, state}, {30'd0, st_exp[i]});
    end
    check("zero_locked", {31'd0, locked}, 32'd1);
    check("zero_err", {16'd0, err_cnt}, 32'd0);

    // 6: error then asynchronous reset between edges
    send(8'h21, 1'b0);
    check("pre_rst_err", {16'd0, err_cnt}, 32'd1);
    check("pre_rst_pulse", {31'd0, err_pulse}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("arst");
    @(negedge clk); rst_n = 1'b1;
    in_data = 8'h55;
    idle(3);
    check("gap_state", {30'd0, state}, 32'd0);
    check("gap_locked", {31'd0, locked}, 32'd0);
    send(8'h55, 1'b0);
    check("gap_hunt", {30'd0, state}, 32'd1);

    // 5: saturation with ERR_W=4
    for (int i = 0; i < 5; i++) send2(seq_a[i], 1'b0);
    check("sat_locked", {31'd0, locked2}, 32'd1);
    p = 8'h10;
    for (int i = 0; i < 20; i++) begin
      send2(p, 1'b0);
      p = nxt(p);
      send2(p ^ 8'hFF, 1'b0);
      p = nxt(p);
      if (i == 0) check("sat_bit1", {28'd0, bit_err_cnt2}, 32'd8);
      if (i == 1) begin
        check("sat_bitclamp", {28'd0, bit_err_cnt2}, 32'd15);
        check("sat_err2", {28'd0, err_cnt2}, 32'd2);
      end
    end
    check("sat_err", {28'd0, err_cnt2}, 32'd15);
    check("sat_bit", {28'd0, bit_err_cnt2}, 32'd15);
    check("sat_locked2", {31'd0, locked2}, 32'd1);
    send2(p ^ 8'hFF, 1'b1);
    p = nxt(p);
    check("clrerr_pulse", {31'd0, err_pulse2}, 32'd1);
    check("clrerr_err", {28'd0, err_cnt2}, 32'd0);
    check("clrerr_bit", {28'd0, bit_err_cnt2}, 32'd0);
    send2(p, 1'b0);
    p = nxt(p);
    check("post_locked", {31'd0, locked2}, 32'd1);
    send2(p ^ 8'hFF, 1'b0);
    check("post_err", {28'd0, err_cnt2}, 32'd1);
    check("post_bit", {28'd0, bit_err_cnt2}, 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
